// File: rtl/lab4_part5_pkg.sv
// ---------------------------------------------------------------------------
// lab4_part5_pkg
//   Shared definitions for the "dE1" ticker-tape display driver:
//   - char_e           : 2-bit character code understood by seg7_char_decoder
//   - SEG_*            : active-low segment patterns, bit order [0:6] = a..g
//   - MSG_ROM          : 8-entry scrolling message ("dE1" followed by blanks)
//   - *_COUNT_DEFAULT  : board defaults (1 s scroll step, 1 ms per digit at 100 MHz)
//   - rom_index()      : message entry shown on a digit for a scroll position
// ---------------------------------------------------------------------------
package lab4_part5_pkg;

  localparam int TICK_COUNT_DEFAULT = 100_000_000;
  localparam int SCAN_COUNT_DEFAULT = 100_000;

  typedef enum logic [1:0] {
    CH_D     = 2'd0,
    CH_E     = 2'd1,
    CH_1     = 2'd2,
    CH_BLANK = 2'd3
  } char_e;

  // Leftmost literal bit is segment a; a 0 lights the segment.
  localparam logic [0:6] SEG_D     = 7'b1000010;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam char_e MSG_ROM [0:7] = '{
    CH_D, CH_E, CH_1, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK
  };

  // Digit 7 is the leftmost, so at pos 0 it shows m[0]; each step of pos
  // shifts the word one digit to the left. 3-bit arithmetic gives the mod 8.
  function automatic logic [2:0] rom_index(input logic [2:0] digit,
                                           input logic [2:0] pos);
    return 3'(3'd7 - digit + pos);
  endfunction

endpackage

// File: rtl/lab4_part5_seg7_char_decoder.sv
// ---------------------------------------------------------------------------
// seg7_char_decoder
//   Maps a 2-bit character code to active-low seven-segment cathodes.
//   Ports:
//     char_i : character code (char_e)
//     seg_o  : segments [0:6] = a..g, 0 = lit
// ---------------------------------------------------------------------------
module seg7_char_decoder
  import lab4_part5_pkg::*;
(
  input  char_e      char_i,
  output logic [0:6] seg_o
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives seg_o;
    // otherwise an uncovered code would infer a latch.
    seg_o = SEG_BLANK;
    case (char_i)
      CH_D:    seg_o = SEG_D;
      CH_E:    seg_o = SEG_E;
      CH_1:    seg_o = SEG_1;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/lab4_part5.sv
// ---------------------------------------------------------------------------
// lab4_part5
//   Ticker-tape driver: scrolls "dE1" around an 8-digit multiplexed
//   seven-segment display, one position per TICK_COUNT clocks, while the
//   digits are time-multiplexed at SCAN_COUNT clocks per digit.
//   Parameters:
//     TICK_COUNT : clocks per scroll step (>= 2)
//     SCAN_COUNT : clocks each digit stays enabled (>= 1)
//   Ports:
//     CLK100MHZ  : system clock, rising edge
//     CPU_RESETN : asynchronous active-low reset
//     HEX0       : shared active-low cathodes [0:6] = a..g for the enabled digit
//     AN         : active-low digit anodes, AN[0] = rightmost
//     LEDR       : current scroll position
// ---------------------------------------------------------------------------
module lab4_part5
  import lab4_part5_pkg::*;
#(
  parameter int TICK_COUNT = TICK_COUNT_DEFAULT,
  parameter int SCAN_COUNT = SCAN_COUNT_DEFAULT
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  output logic [0:6] HEX0,
  output logic [7:0] AN,
  output logic [2:0] LEDR
);

  // A single-cycle scan still needs a 1-bit counter to hold the constant 0.
  localparam int TICK_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int SCAN_W = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_COUNT - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]        pos_q,      pos_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]        scan_idx_q, scan_idx_d;

  logic  tick_wrap;
  logic  scan_wrap;
  char_e cur_char;

  // Scroll and scan prescalers are independent; both may wrap on one edge.
  always_comb begin
    tick_wrap  = (tick_cnt_q == TICK_LAST);
    scan_wrap  = (scan_cnt_q == SCAN_LAST);

    tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
    pos_d      = tick_wrap ? pos_q + 3'd1 : pos_q;

    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    scan_idx_d = scan_wrap ? scan_idx_q + 3'd1 : scan_idx_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      tick_cnt_q <= '0;
      pos_q      <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pos_q      <= pos_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  // Outputs decode registered state directly, so there is no added latency
  // and only one anode can ever be low.
  always_comb begin
    AN       = ~(8'b1 << scan_idx_q);
    cur_char = MSG_ROM[rom_index(scan_idx_q, pos_q)];
    LEDR     = pos_q;
  end

  seg7_char_decoder u_decoder (
    .char_i (cur_char),
    .seg_o  (HEX0)
  );

endmodule

// File: tb/tb_lab4_part5.sv
// ---------------------------------------------------------------------------
// tb_lab4_part5
//   Directed bench for lab4_part5. u_fast (TICK_COUNT=8, SCAN_COUNT=2) covers
//   scroll timing and scan rotation. u_slow (TICK_COUNT=32, SCAN_COUNT=2)
//   holds each position for two full scans so every digit can be read at
//   every position. After k clock edges from reset release:
//     s = (k/2) % 8, fast pos = (k/8) % 8, slow pos = (k/32) % 8.
// ---------------------------------------------------------------------------
module tb_lab4_part5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:6] f_hex, s_hex;
  logic [7:0] f_an, s_an;
  logic [2:0] f_ledr, s_ledr;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  always #5 clk = ~clk;

  lab4_part5 #(.TICK_COUNT(8), .SCAN_COUNT(2)) u_fast (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .HEX0       (f_hex),
    .AN         (f_an),
    .LEDR       (f_ledr)
  );

  lab4_part5 #(.TICK_COUNT(32), .SCAN_COUNT(2)) u_slow (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .HEX0       (s_hex),
    .AN         (s_an),
    .LEDR       (s_ledr)
  );

  localparam logic [6:0] C_D     = 7'b1000010;
  localparam logic [6:0] C_E     = 7'b0110000;
  localparam logic [6:0] C_1     = 7'b1001111;
  localparam logic [6:0] C_BLANK = 7'b1111111;

  function automatic logic [7:0] exp_an(input int s);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << s);
  endfunction

  // Character expected on digit j at scroll position p: m[(7 - j + p) mod 8].
  function automatic logic [6:0] exp_hex(input int j, input int p);
    int idx;
    idx = (7 - j + p) % 8;
    case (idx)
      0:       return C_D;
      1:       return C_E;
      2:       return C_1;
      default: return C_BLANK;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  initial begin
    // Reset held for three edges.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ledr", 32'(f_ledr), 32'd0);
    check("rst_an",   32'(f_an),   32'hFE);
    check("rst_hex",  32'(f_hex),  32'(C_BLANK));
    check("rst_slow_an", 32'(s_an), 32'hFE);

    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    for (int n = 1; n <= 256; n++) begin
      step();
      if (k <= 64) begin
        check("fast_ledr",   32'(f_ledr), 32'((k / 8) % 8));
        check("fast_an",     32'(f_an),   32'(exp_an((k / 2) % 8)));
        check("fast_onehot", 32'($countones(~f_an)), 32'd1);
        check("fast_hex",    32'(f_hex),  32'(exp_hex((k / 2) % 8, (k / 8) % 8)));
      end
      check("slow_ledr", 32'(s_ledr), 32'((k / 32) % 8));
      check("slow_an",   32'(s_an),   32'(exp_an((k / 2) % 8)));
      check("slow_hex",  32'(s_hex),  32'(exp_hex((k / 2) % 8, (k / 32) % 8)));

      // Hand-derived directed points.
      case (k)
        7:   check("fast_before_step", 32'(f_ledr), 32'd0);
        8:   check("fast_first_step",  32'(f_ledr), 32'd1);
        16:  check("fast_second_step", 32'(f_ledr), 32'd2);
        63:  check("fast_pos7",        32'(f_ledr), 32'd7);
        64:  check("fast_wrap",        32'(f_ledr), 32'd0);
        2:   check("pos0_dig1_blank",  32'(s_hex),  32'(C_BLANK));
        10:  check("pos0_dig5_1",      32'(s_hex),  32'(C_1));
        12:  check("pos0_dig6_E",      32'(s_hex),  32'(C_E));
        14:  check("pos0_dig7_d",      32'(s_hex),  32'(C_D));
        44:  check("pos1_dig6_1",      32'(s_hex),  32'(C_1));
        46:  check("pos1_dig7_E",      32'(s_hex),  32'(C_E));
        48:  check("pos1_dig0_d",      32'(s_hex),  32'(C_D));
        224: check("pos7_dig0_blank",  32'(s_hex),  32'(C_BLANK));
        232: check("pos7_dig4_1",      32'(s_hex),  32'(C_1));
        234: check("pos7_dig5_E",      32'(s_hex),  32'(C_E));
        236: check("pos7_dig6_d",      32'(s_hex),  32'(C_D));
        238: check("pos7_dig7_blank",  32'(s_hex),  32'(C_BLANK));
        default: ;
      endcase
    end

    // Advance the slow instance to pos=5, s=3 (k=422).
    repeat (166) step();
    check("pre_rst_slow_ledr", 32'(s_ledr), 32'd5);
    check("pre_rst_slow_an",   32'(s_an),   32'hF7);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_slow_ledr", 32'(s_ledr), 32'd0);
    check("async_slow_an",   32'(s_an),   32'hFE);
    check("async_slow_hex",  32'(s_hex),  32'(C_BLANK));
    check("async_fast_ledr", 32'(f_ledr), 32'd0);
    check("async_fast_an",   32'(f_an),   32'hFE);

    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    repeat (7) step();
    check("post_rst_fast_hold", 32'(f_ledr), 32'd0);
    step();
    check("post_rst_fast_step", 32'(f_ledr), 32'd1);
    repeat (23) step();
    check("post_rst_slow_hold", 32'(s_ledr), 32'd0);
    step();
    check("post_rst_slow_step", 32'(s_ledr), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
